s_spi_slave_rx_tx: RTL and testbench
====================================

// Module: s_spi_slave_rx_tx
// PURPOSE
//  SPI mode-0 slave byte engine on the SLAVE board; feeds the slave top-level message buffer.
//  Oversamples raw SCLK/MOSI/SS in the system clock domain and shifts bytes in/out MSB-first.
//  Emits one-cycle strobes per received byte (rx_valid) and per consumed TX byte (tx_req).
//  Frame control: SS active-low. SCLK must run <= clk/8.
// PARAMETERS
//  DATA_W       8   bits per SPI word
//  SYNC_STAGES  2   flops in each input synchronizer (>=2)
//  IDLE_MISO    0   level driven on MISO while SS is high
// PORTS
//  clk        in   1       system clock (27 MHz on board)
//  rst        in   1       asynchronous, active-high reset
//  SCLK       in   1       raw SPI clock from master (async)
//  MOSI       in   1       raw master-out data (async)
//  SS         in   1       raw slave select, active low (async)
//  MISO       out  1       slave-out data, MSB first
//  tx_data    in   DATA_W  next byte to send; sampled at frame start and at each byte boundary
//  tx_req     out  1       1-cycle pulse: tx_data consumed, present next byte
//  rx_data    out  DATA_W  last complete received byte; held until next byte completes
//  rx_valid   out  1       1-cycle pulse: rx_data updated
//  busy       out  1       high while the frame is active (synchronized SS low)
//  frame_err  out  1       1-cycle pulse: SS released with a partial byte (bit_cnt != 0)
// BEHAVIOUR
//  Reset: MISO=IDLE_MISO, tx_req=0, rx_data=0, rx_valid=0, busy=0, frame_err=0; FSM=IDLE;
//   shift regs=0, bit_cnt=0; synchronizers reset to SCLK=0, SS=1, MOSI=0.
//  Inputs pass through SYNC_STAGES flops, then a 1-flop edge detector: sclk_rise, sclk_fall,
//   ss_fall, ss_rise are single-cycle strobes, SYNC_STAGES+1 clk after the pin edge.
//  FSM IDLE: MISO=IDLE_MISO. On ss_fall -> ACTIVE: tx_shift<=tx_data, bit_cnt<=0, tx_req pulse
//   in the same cycle, busy=1 from next cycle.
//  FSM ACTIVE: MISO = tx_shift[DATA_W-1] (combinational from register).
//   sclk_rise: rx_shift <= {rx_shift[DATA_W-2:0], mosi_s}; bit_cnt <= bit_cnt+1 (wraps at DATA_W).
//   On the rise where bit_cnt==DATA_W-1: rx_data <= {rx_shift[DATA_W-2:0], mosi_s};
//    rx_valid pulses the following cycle; bit_cnt -> 0.
//   sclk_fall with bit_cnt!=0: tx_shift <= tx_shift<<1 (zero fill).
//   sclk_fall with bit_cnt==0 (byte boundary, not the first fall of the frame):
//    tx_shift<=tx_data, tx_req pulse. The first fall after ss_fall with bit_cnt==0 is ignored.
//   ss_rise -> IDLE; if bit_cnt!=0 pulse frame_err, discard partial rx_shift, no rx_valid.
//  Simultaneous strobes in one cycle: ss_rise wins over sclk edges; sclk_rise and sclk_fall in
//   the same cycle are impossible given the SCLK <= clk/8 rule and need no handling.
//  ss_fall while already ACTIVE (glitch): ignored. SCLK edges while IDLE: ignored, no counting.
//  rst mid-frame: immediate return to reset values; the next byte needs a fresh ss_fall.
//  tx_req/rx_valid never both high from the same edge; each is exactly 1 clk wide.
// STRUCTURE
//  Shared include s_spi_defs.vh: DATA_W default, FSM state encodings (IDLE=1'b0, ACTIVE=1'b1),
//   and the minimum SCLK divide ratio constant (8).
//  Sub-module s_sync_edge (parameter SYNC_STAGES, RESET_VAL): synchronizer plus rise/fall
//   strobes; one instance each for SCLK and SS. MOSI uses the synchronizer path only.
//  Top-level of this block: FSM, bit counter, rx/tx shift registers, output strobes.
// TESTING
//  1 Reset, SS high, SCLK toggling -> MISO=0, no rx_valid/tx_req, busy=0.
//  2 tx_data=8'hA5; master sends 8'h3C, SCLK=clk/8 -> tx_req at frame start; rx_data=8'h3C
//    with a single rx_valid; MISO bits sampled by master = 1,0,1,0,0,1,0,1.
//  3 Two-byte frame sending 8'h46,8'h52; tx_data changes 8'h46->8'h52 after first tx_req ->
//    two rx_valid pulses (8'h46 then 8'h52); master receives 8'h46,8'h52; exactly 2 tx_req.
//  4 SS released after 5 bits -> frame_err pulse, no rx_valid, rx_data keeps prior 8'h3C;
//    next full frame with 8'h55 received correctly.
//  5 Assert rst after 3 bits of a frame, release while SS still low -> block stays IDLE;
//    no rx_valid until SS toggles high then low; the new frame with 8'hFF received intact.
//  6 SS glitch: SS low for 1 clk (shorter than the sync depth) -> no busy, no tx_req.

Source files
------------

// File: rtl/s_spi_slave_rx_tx_pkg.sv
// Shared constants and FSM state encoding for the SPI mode-0 slave byte engine.
package s_spi_slave_rx_tx_pkg;
  localparam int DEF_DATA_W   = 8;
  localparam int MIN_SCLK_DIV = 8;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;
endpackage

// File: rtl/s_spi_slave_rx_tx_sync_edge.sv
// Multi-flop synchronizer for one async pin, followed by a one-flop edge detector
// that produces single-cycle rise/fall strobes.
module s_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;
endmodule

// File: rtl/s_spi_slave_rx_tx.sv
// SPI mode-0 slave byte engine: oversampled SCLK/MOSI/SS, MSB-first shifting,
// per-byte rx_valid and tx_req strobes, frame_err on a truncated byte.
module s_spi_slave_rx_tx
  import s_spi_slave_rx_tx_pkg::*;
#(
  parameter int   DATA_W      = DEF_DATA_W,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SCLK,
  input  logic              MOSI,
  input  logic              SS,
  output logic              MISO,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_req,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              frame_err
);
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

  state_t                 state, state_next;
  logic                   sclk_s, sclk_rise, sclk_fall;
  logic                   ss_s, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   mosi_s;
  logic [DATA_W-1:0]      tx_shift, rx_shift;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   first_fall;
  logic [SETTLE_W-1:0]    settle_cnt;
  logic                   armed;
  logic                   start, end_frame, load_tx, shift_tx, take_bit, byte_done, fall_seen;

  s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .rst(rst), .din(SCLK), .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  s_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clk(clk), .rst(rst), .din(SS), .level(ss_s), .rise(ss_rise), .fall(ss_fall)
  );

  assign mosi_s = mosi_chain[SYNC_STAGES-1];

  // A frame may only start after SS has been seen high once the synchronizers settle,
  // so releasing reset while SS is already low does not fake a frame start.
  always_comb begin
    state_next = state;
    tx_req     = 1'b0;
    frame_err  = 1'b0;
    start      = 1'b0;
    end_frame  = 1'b0;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    take_bit   = 1'b0;
    fall_seen  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ss_fall && armed) begin
          state_next = ST_ACTIVE;
          start      = 1'b1;
          load_tx    = 1'b1;
          tx_req     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (ss_rise) begin
          state_next = ST_IDLE;
          end_frame  = 1'b1;
          frame_err  = (bit_cnt != '0);
        end else begin
          take_bit  = sclk_rise;
          fall_seen = sclk_fall;
          if (sclk_fall) begin
            if (bit_cnt != '0) begin
              shift_tx = 1'b1;
            end else if (!first_fall) begin
              load_tx = 1'b1;
              tx_req  = 1'b1;
            end
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign byte_done = take_bit && (bit_cnt == LAST_BIT);

  // A fall with bit_cnt==0 can only precede the first rise if SCLK was high at frame start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      mosi_chain <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      bit_cnt    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      first_fall <= 1'b0;
      settle_cnt <= '0;
      armed      <= 1'b0;
    end else begin
      state      <= state_next;
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], MOSI};
      rx_valid   <= byte_done;
      if (settle_cnt != SETTLE_DONE) settle_cnt <= settle_cnt + 1'b1;
      else if (ss_s) armed <= 1'b1;
      if (load_tx) tx_shift <= tx_data;
      else if (shift_tx) tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
      if (start) begin
        bit_cnt    <= '0;
        rx_shift   <= '0;
        first_fall <= sclk_s;
      end else if (end_frame) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else begin
        if (fall_seen) first_fall <= 1'b0;
        if (take_bit) begin
          rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
          bit_cnt  <= byte_done ? '0 : bit_cnt + 1'b1;
        end
      end
      if (byte_done) rx_data <= {rx_shift[DATA_W-2:0], mosi_s};
    end
  end

  assign busy = (state == ST_ACTIVE);
  assign MISO = (state == ST_ACTIVE) ? tx_shift[DATA_W-1] : IDLE_MISO;
endmodule

// File: tb/tb_s_spi_slave_rx_tx.sv
// Self-checking bench: a behavioural SPI mode-0 master drives frames and a byte-level
// model predicts received bytes, tx_req counts, frame errors and MISO contents.
module tb_s_spi_slave_rx_tx;
  import s_spi_slave_rx_tx_pkg::*;

  localparam int HALF = MIN_SCLK_DIV / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       SCLK, MOSI, SS;
  logic       MISO;
  logic [7:0] tx_data;
  logic       tx_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       frame_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mosi_arr [0:7];
  logic [7:0] tx_arr   [0:7];
  logic [7:0] rx_all   [$];
  logic [7:0] got_bytes[$];
  int tx_req_total = 0, tx_base = 0, tx_sel;
  int ferr_total = 0, busy_total = 0, width_err = 0;
  int rx_base, ferr_base, busy_base, start_req;
  int exp_k, exp_p;
  logic [7:0] exp_last = 8'h00;
  logic rv_prev = 1'b0, tr_prev = 1'b0;

  s_spi_slave_rx_tx dut (
    .clk(clk), .rst(rst), .SCLK(SCLK), .MOSI(MOSI), .SS(SS), .MISO(MISO),
    .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  assign tx_sel  = tx_req_total - tx_base;
  assign tx_data = (tx_sel >= 0 && tx_sel < 8) ? tx_arr[tx_sel[2:0]] : 8'h00;

  always @(negedge clk) begin
    if (rx_valid) rx_all.push_back(rx_data);
    if (rx_valid && rv_prev) width_err++;
    if (tx_req && tr_prev) width_err++;
    rv_prev = rx_valid;
    tr_prev = tx_req;
    if (frame_err) ferr_total++;
    if (busy) busy_total++;
  end

  // The slave consumes tx_data on the edge ending the tx_req cycle; present the next byte after it.
  always @(negedge clk) begin
    if (tx_req) begin
      @(posedge clk);
      #1;
      tx_req_total++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit last, output logic m);
    MOSI = b;
    wait_clk(HALF);
    m = MISO;
    SCLK = 1'b1;
    wait_clk(HALF);
    SCLK = 1'b0;
    if (last) SS = 1'b1;
  endtask

  task automatic run_frame(input int nbits);
    logic [7:0] cur, acc;
    logic b, m;
    rx_base   = rx_all.size();
    tx_base   = tx_req_total;
    ferr_base = ferr_total;
    busy_base = busy_total;
    got_bytes.delete();
    acc = 8'h00;
    SS = 1'b0;
    wait_clk(8);
    start_req = tx_req_total - tx_base;
    for (int n = 0; n < nbits; n++) begin
      cur = mosi_arr[n / 8];
      b = cur[7 - (n % 8)];
      send_bit(b, n == nbits - 1, m);
      acc = {acc[6:0], m};
      if (n % 8 == 7) got_bytes.push_back(acc);
    end
    wait_clk(16);
    exp_k = nbits / 8;
    exp_p = nbits % 8;
    if (exp_k > 0) exp_last = mosi_arr[exp_k - 1];
  endtask

  task automatic test_reset;
    rst = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    wait_clk(3);
    n_checks++; if (MISO !== 1'b0) $display("[TB] FAIL reset_miso: got %b required 0", MISO); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("[TB] FAIL reset_rx_data: got %h required 00", rx_data); else n_pass++;
    n_checks++; if ({rx_valid, tx_req, busy, frame_err} !== 4'b0) $display("[TB] FAIL reset_strobes: got %b required 0000", {rx_valid, tx_req, busy, frame_err}); else n_pass++;
    rst = 1'b0;
    wait_clk(6);
    rx_base = rx_all.size(); tx_base = tx_req_total; busy_base = busy_total;
    for (int i = 0; i < 10; i++) begin
      SCLK = 1'b1; MOSI = $urandom_range(0, 1); wait_clk(HALF);
      SCLK = 1'b0; wait_clk(HALF);
    end
    wait_clk(6);
    n_checks++; if (MISO !== 1'b0) $display("[TB] FAIL idle_miso: got %b required 0", MISO); else n_pass++;
    n_checks++; if (rx_all.size() != rx_base) $display("[TB] FAIL idle_rx_valid: got %0d required 0", rx_all.size() - rx_base); else n_pass++;
    n_checks++; if (tx_req_total != tx_base) $display("[TB] FAIL idle_tx_req: got %0d required 0", tx_req_total - tx_base); else n_pass++;
    n_checks++; if (busy_total != busy_base) $display("[TB] FAIL idle_busy: got %0d cycles required 0", busy_total - busy_base); else n_pass++;
  endtask

  task automatic test_single_byte;
    mosi_arr[0] = 8'h3C; tx_arr[0] = 8'hA5; tx_arr[1] = 8'($urandom);
    run_frame(8);
    n_checks++; if (start_req != 1) $display("[TB] FAIL single_start_req: got %0d required 1", start_req); else n_pass++;
    n_checks++; if (rx_all.size() - rx_base != 1) $display("[TB] FAIL single_rx_count: got %0d required 1", rx_all.size() - rx_base); else n_pass++;
    n_checks++; if (rx_data !== 8'h3C) $display("[TB] FAIL single_rx_data: got %h required 3c", rx_data); else n_pass++;
    n_checks++; if (got_bytes.size() != 1 || got_bytes[0] !== 8'hA5) $display("[TB] FAIL single_miso: got %h required a5", (got_bytes.size() > 0) ? got_bytes[0] : 8'hxx); else n_pass++;
    n_checks++; if (tx_req_total - tx_base != 1) $display("[TB] FAIL single_tx_req: got %0d required 1", tx_req_total - tx_base); else n_pass++;
    n_checks++; if (busy !== 1'b0 || busy_total == busy_base) $display("[TB] FAIL single_busy: got now=%b cycles=%0d required now=0 cycles>0", busy, busy_total - busy_base); else n_pass++;
  endtask

  task automatic test_partial_frame;
    mosi_arr[0] = 8'($urandom); tx_arr[0] = 8'($urandom);
    run_frame(5);
    n_checks++; if (ferr_total - ferr_base != 1) $display("[TB] FAIL partial_frame_err: got %0d required 1", ferr_total - ferr_base); else n_pass++;
    n_checks++; if (rx_all.size() != rx_base) $display("[TB] FAIL partial_rx_valid: got %0d required 0", rx_all.size() - rx_base); else n_pass++;
    n_checks++; if (rx_data !== 8'h3C) $display("[TB] FAIL partial_rx_hold: got %h required 3c", rx_data); else n_pass++;
    mosi_arr[0] = 8'h55; tx_arr[0] = 8'($urandom);
    run_frame(8);
    n_checks++; if (rx_all.size() - rx_base != 1 || rx_data !== 8'h55) $display("[TB] FAIL partial_next_frame: got %h required 55", rx_data); else n_pass++;
    n_checks++; if (ferr_total != ferr_base) $display("[TB] FAIL partial_next_ferr: got %0d required 0", ferr_total - ferr_base); else n_pass++;
  endtask

  task automatic test_back_to_back;
    mosi_arr[0] = 8'h46; mosi_arr[1] = 8'h52;
    tx_arr[0] = 8'h46; tx_arr[1] = 8'h52; tx_arr[2] = 8'($urandom);
    run_frame(16);
    n_checks++; if (rx_all.size() - rx_base != 2) $display("[TB] FAIL b2b_rx_count: got %0d required 2", rx_all.size() - rx_base); else n_pass++;
    n_checks++; if (rx_all.size() - rx_base == 2 && (rx_all[rx_base] !== 8'h46 || rx_all[rx_base + 1] !== 8'h52)) $display("[TB] FAIL b2b_rx_bytes: got %h %h required 46 52", rx_all[rx_base], rx_all[rx_base + 1]); else n_pass++;
    n_checks++; if (got_bytes.size() != 2 || got_bytes[0] !== 8'h46 || got_bytes[1] !== 8'h52) $display("[TB] FAIL b2b_miso: got %0d bytes required 46 52", got_bytes.size()); else n_pass++;
    n_checks++; if (tx_req_total - tx_base != 2) $display("[TB] FAIL b2b_tx_req: got %0d required 2", tx_req_total - tx_base); else n_pass++;
    n_checks++; if (width_err != 0) $display("[TB] FAIL strobe_width: got %0d wide pulses required 0", width_err); else n_pass++;
  endtask

  task automatic test_reset_mid_frame;
    logic m;
    tx_arr[0] = 8'($urandom);
    SS = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, m);
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    exp_last = 8'h00;
    wait_clk(4);
    rx_base = rx_all.size(); tx_base = tx_req_total; busy_base = busy_total;
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0, m);
    wait_clk(8);
    n_checks++; if (rx_data !== exp_last) $display("[TB] FAIL rstmid_rx_data: got %h required %h", rx_data, exp_last); else n_pass++;
    n_checks++; if (busy_total != busy_base) $display("[TB] FAIL rstmid_busy: got %0d cycles required 0", busy_total - busy_base); else n_pass++;
    n_checks++; if (rx_all.size() != rx_base || tx_req_total != tx_base) $display("[TB] FAIL rstmid_strobes: got rx=%0d req=%0d required 0 0", rx_all.size() - rx_base, tx_req_total - tx_base); else n_pass++;
    SS = 1'b1;
    wait_clk(16);
    mosi_arr[0] = 8'hFF; tx_arr[0] = 8'($urandom);
    run_frame(8);
    n_checks++; if (rx_all.size() - rx_base != 1 || rx_data !== 8'hFF) $display("[TB] FAIL rstmid_next_frame: got %h required ff", rx_data); else n_pass++;
  endtask

  task automatic test_ss_glitch;
    busy_base = busy_total; tx_base = tx_req_total; ferr_base = ferr_total;
    @(posedge clk);
    #2 SS = 1'b0;
    #5 SS = 1'b1;
    wait_clk(12);
    n_checks++; if (busy_total != busy_base) $display("[TB] FAIL glitch_busy: got %0d cycles required 0", busy_total - busy_base); else n_pass++;
    n_checks++; if (tx_req_total != tx_base) $display("[TB] FAIL glitch_tx_req: got %0d required 0", tx_req_total - tx_base); else n_pass++;
  endtask

  task automatic test_random_frames;
    int nbits, exp_req, nbytes;
    for (int f = 0; f < 8; f++) begin
      nbits = $urandom_range(1, 24);
      nbytes = (nbits + 7) / 8;
      for (int i = 0; i < 8; i++) begin
        mosi_arr[i] = 8'($urandom);
        tx_arr[i]   = 8'($urandom);
      end
      run_frame(nbits);
      exp_req = exp_k + ((exp_p > 0) ? 1 : 0);
      n_checks++; if (rx_all.size() - rx_base != exp_k) $display("[TB] FAIL rand%0d_rx_count: got %0d required %0d", f, rx_all.size() - rx_base, exp_k); else n_pass++;
      for (int i = 0; i < exp_k && i < rx_all.size() - rx_base; i++) begin
        n_checks++; if (rx_all[rx_base + i] !== mosi_arr[i]) $display("[TB] FAIL rand%0d_rx_byte%0d: got %h required %h", f, i, rx_all[rx_base + i], mosi_arr[i]); else n_pass++;
      end
      for (int i = 0; i < exp_k && i < got_bytes.size(); i++) begin
        n_checks++; if (got_bytes[i] !== tx_arr[i]) $display("[TB] FAIL rand%0d_miso_byte%0d: got %h required %h", f, i, got_bytes[i], tx_arr[i]); else n_pass++;
      end
      n_checks++; if (tx_req_total - tx_base != exp_req) $display("[TB] FAIL rand%0d_tx_req: got %0d required %0d (bytes %0d)", f, tx_req_total - tx_base, exp_req, nbytes); else n_pass++;
      n_checks++; if (ferr_total - ferr_base != ((exp_p > 0) ? 1 : 0)) $display("[TB] FAIL rand%0d_frame_err: got %0d required %0d", f, ferr_total - ferr_base, (exp_p > 0) ? 1 : 0); else n_pass++;
      n_checks++; if (rx_data !== exp_last) $display("[TB] FAIL rand%0d_rx_data: got %h required %h", f, rx_data, exp_last); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mosi_arr[i] = 8'h00;
      tx_arr[i]   = 8'h00;
    end
    test_reset();
    test_single_byte();
    test_partial_frame();
    test_back_to_back();
    test_reset_mid_frame();
    test_ss_glitch();
    test_random_frames();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
